muldiv_arbiter: RTL
===================

Name: muldiv_arbiter

Overview:
- Shares one iterative unsigned multiply/divide unit between the two execute pipes (slot 0 = older, slot 1 = younger) of the dual-issue execute stage.
- Accepts one request at a time and converts signed operands to magnitudes. It starts the unit, waits for completion, then applies sign fix-up and holds the 64-bit {hi,lo} result for the winning slot until that slot consumes it.
- Handles pipeline flush: an in-flight operation is drained and its result discarded.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  2  per-slot request valid; a request is held until accepted
- req_op  in  2x2  per-slot op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- req_a  in  2xWIDTH  per-slot operand a (vs)
- req_b  in  2xWIDTH  per-slot operand b (vt)
- req_ready  out  2  per-slot accept; request is taken when valid&ready
- flush  in  1  kill the accepted or in-flight operation
- resp_valid  out  1  result available
- resp_slot  out  1  slot that owns the result
- resp_hi  out  WIDTH  hi (mult high word / remainder)
- resp_lo  out  WIDTH  lo (mult low word / quotient)
- resp_ready  in  1  owning slot consumes the result
- unit_start  out  1  one-cycle start pulse to the unit
- unit_div  out  1  1 = divide, 0 = multiply
- unit_a, unit_b  out  WIDTH  unsigned magnitudes
- unit_done  in  1  one-cycle completion pulse
- unit_hi, unit_lo  in  WIDTH  unsigned unit result

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (resetn).
- Reset values: state=IDLE; req_ready=00; resp_valid=0; resp_slot=0; resp_hi=resp_lo=0; unit_start=0; unit_div=0; unit_a=unit_b=0.
- States: IDLE, START, BUSY, DONE, DRAIN.
- IDLE:
  - req_ready is asserted combinationally toward the winning valid slot; slot 0 wins over slot 1 (program order).
  - On accept, latch slot, op, signed flag, neg_a=a[W-1]&signed and neg_b=b[W-1]&signed, and magnitudes |a|, |b|. Two's-complement negate; 0x80000000 maps to itself and is read as unsigned 2^31.
  - Next state is START.
- START: unit_start=1 for exactly one cycle with unit_div, unit_a, unit_b stable → BUSY. unit_a/unit_b/unit_div stay stable until unit_done.
- BUSY:
  - Wait for unit_done, then register the fixed-up result → DONE.
  - Multiply sign fix-up: if neg_a^neg_b, negate the 64-bit product.
  - Divide sign fix-up: lo = quotient, negated if neg_a^neg_b; hi = remainder, negated if neg_a (remainder takes the dividend's sign).
- Divide by zero (b==0, DIV or DIVU): the unit is not started. START goes straight to DONE with hi=a (original, unmodified) and lo=all ones. This is a fixed, team-defined result.
- DONE: resp_valid=1 with stable slot, hi, lo. On resp_ready → IDLE, and the next request may be accepted in the following cycle (no same-cycle re-accept).
- Latency: accept at cycle t → unit_start at t+1 → resp_valid the cycle after unit_done. Divide-by-zero: resp_valid at t+2.
- Flush:
  - In START or BUSY: go to DRAIN. unit_start is still issued if it was due this cycle, because the unit cannot abort.
  - DRAIN: req_ready=00; on unit_done → IDLE, result discarded, resp_valid never asserted.
  - In DONE: resp_valid drops next cycle → IDLE.
  - In IDLE: flush has priority over accept, so req_ready=00 that cycle.
- A unit_done pulse outside BUSY/DRAIN is ignored.
- resp_ready while resp_valid=0 is ignored.
- resetn low in any state, including BUSY, forces IDLE next edge. The unit must be reset by the same resetn.

Decomposition:
- Shared package (mycpu): muldiv_op_t (2-bit enum), muldiv_state_t, DIV0_LO constant (all ones), and a muldiv_req_t struct {valid, op, a, b}.
- One sub-module: muldiv_signfix. It is combinational and takes neg_a, neg_b, is_div, unit_hi and unit_lo, producing fixed hi/lo. It is reused by the ALU-side MUL path.

Test Plan:
- Slot 0 MULT a=-3, b=7; unit returns 0x0:0x15 after 4 cycles → unit_a=3, unit_b=7, resp hi=0xFFFFFFFF, lo=0xFFFFFFEB, slot 0, resp_valid one cycle after unit_done.
- Both slots valid the same cycle (slot0 DIVU 100/7, slot1 MULTU 2*3) → slot 0 granted first: resp hi=2, lo=14; after resp_ready, slot 1 is granted: resp hi=0, lo=6.
- DIV a=-7, b=2 → unit_a=7, unit_b=2; unit q=3, r=1 → resp lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 → unit_start never pulses; resp hi=5, lo=0xFFFFFFFF at accept+2.
- Flush asserted in BUSY; unit_done arrives 3 cycles later → resp_valid stays 0, req_ready=00 until the cycle after unit_done, then a new request is accepted.
- resetn low during BUSY, then high → all outputs at reset values; a pending req_valid is granted in the first cycle after reset.

Source files
------------

// File: rtl/muldiv_arbiter_pkg.sv
// Shared types for the mul/div arbiter and its sign fix-up helper.
//   muldiv_op_t    : 2-bit op encoding seen on req_op
//   muldiv_state_t : arbiter FSM states
//   DIV0_LO        : lo word returned for divide-by-zero (all ones)
//   muldiv_req_t   : per-slot request bundle {valid, op, a, b}
package mycpu;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_START,
        MD_BUSY,
        MD_DONE,
        MD_DRAIN
    } muldiv_state_t;

    localparam logic [XLEN-1:0] DIV0_LO = '1;

    typedef struct packed {
        logic            valid;
        muldiv_op_t      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } muldiv_req_t;
endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign fix-up for an unsigned mul/div unit result.
//   neg_a_i, neg_b_i : operand signs (already qualified by signed op)
//   is_div_i         : 1 = result is {remainder, quotient}, 0 = 64-bit product
//   unit_hi_i/lo_i   : raw unsigned unit result
//   fix_hi_o/lo_o    : signed-corrected hi/lo
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             neg_a_i,
    input  logic             neg_b_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] unit_hi_i,
    input  logic [WIDTH-1:0] unit_lo_i,
    output logic [WIDTH-1:0] fix_hi_o,
    output logic [WIDTH-1:0] fix_lo_o
);
    logic               neg_res;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        neg_res  = neg_a_i ^ neg_b_i;
        prod     = {unit_hi_i, unit_lo_i};
        prod_fix = neg_res ? -prod : prod;
        if (is_div_i) begin
            fix_lo_o = neg_res ? -unit_lo_i : unit_lo_i;
            // remainder follows the dividend's sign
            fix_hi_o = neg_a_i ? -unit_hi_i : unit_hi_i;
        end else begin
            {fix_hi_o, fix_lo_o} = prod_fix;
        end
    end
endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative unsigned mul/div unit between two execute slots.
// Slot 0 (older) wins over slot 1. Operands are converted to magnitudes,
// the unit is started, and the sign-fixed {hi,lo} result is held until the
// owning slot consumes it. Flush drains any started operation silently.
//   req_*   : per-slot request (valid/op/a/b) and combinational ready
//   flush   : kill accepted / in-flight / completed operation
//   resp_*  : registered result toward the owning slot
//   unit_*  : start/operands to the unit, done/result from it
module muldiv_arbiter
    import mycpu::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            req_valid,
    input  logic [1:0][1:0]       req_op,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic [1:0]            req_ready,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic                  resp_slot,
    output logic [WIDTH-1:0]      resp_hi,
    output logic [WIDTH-1:0]      resp_lo,
    input  logic                  resp_ready,
    output logic                  unit_start,
    output logic                  unit_div,
    output logic [WIDTH-1:0]      unit_a,
    output logic [WIDTH-1:0]      unit_b,
    input  logic                  unit_done,
    input  logic [WIDTH-1:0]      unit_hi,
    input  logic [WIDTH-1:0]      unit_lo
);
    muldiv_state_t    state_q;
    logic             resp_valid_q, resp_slot_q;
    logic [WIDTH-1:0] resp_hi_q, resp_lo_q;
    logic             unit_start_q, unit_div_q;
    logic [WIDTH-1:0] unit_a_q, unit_b_q;
    logic [WIDTH-1:0] a_raw_q;
    logic             neg_a_q, neg_b_q, div0_q;

    // winning-slot view of the request
    logic             sel;
    muldiv_op_t       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_signed, sel_div, sel_na, sel_nb, sel_div0, accept;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    always_comb begin
        sel        = ~req_valid[0];
        sel_op     = muldiv_op_t'(req_op[sel]);
        sel_a      = req_a[sel];
        sel_b      = req_b[sel];
        sel_signed = (sel_op == OP_MULT) || (sel_op == OP_DIV);
        sel_div    = (sel_op == OP_DIVU) || (sel_op == OP_DIV);
        sel_na     = sel_a[WIDTH-1] & sel_signed;
        sel_nb     = sel_b[WIDTH-1] & sel_signed;
        sel_div0   = sel_div && (sel_b == '0);
        // flush beats accept; nothing is granted while in reset
        req_ready  = '0;
        if (resetn && state_q == MD_IDLE && !flush) begin
            if (req_valid[0])      req_ready = 2'b01;
            else if (req_valid[1]) req_ready = 2'b10;
        end
        accept = |(req_valid & req_ready);
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .neg_a_i   (neg_a_q),
        .neg_b_i   (neg_b_q),
        .is_div_i  (unit_div_q),
        .unit_hi_i (unit_hi),
        .unit_lo_i (unit_lo),
        .fix_hi_o  (fix_hi),
        .fix_lo_o  (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= MD_IDLE;
            resp_valid_q <= 1'b0;
            resp_slot_q  <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo_q    <= '0;
            unit_start_q <= 1'b0;
            unit_div_q   <= 1'b0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            a_raw_q      <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            div0_q       <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: if (accept) begin
                    state_q      <= MD_START;
                    resp_slot_q  <= sel;
                    neg_a_q      <= sel_na;
                    neg_b_q      <= sel_nb;
                    a_raw_q      <= sel_a;
                    unit_div_q   <= sel_div;
                    // most-negative value negates to itself = unsigned 2^(W-1)
                    unit_a_q     <= sel_na ? -sel_a : sel_a;
                    unit_b_q     <= sel_nb ? -sel_b : sel_b;
                    div0_q       <= sel_div0;
                    unit_start_q <= ~sel_div0;
                end
                MD_START: begin
                    unit_start_q <= 1'b0;
                    if (div0_q) begin
                        // unit never started, so a flush has nothing to drain
                        if (flush) begin
                            state_q <= MD_IDLE;
                        end else begin
                            state_q      <= MD_DONE;
                            resp_valid_q <= 1'b1;
                            resp_hi_q    <= a_raw_q;
                            resp_lo_q    <= DIV0_LO;
                        end
                    end else begin
                        state_q <= flush ? MD_DRAIN : MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (unit_done) begin
                        if (flush) begin
                            state_q <= MD_IDLE;
                        end else begin
                            state_q      <= MD_DONE;
                            resp_valid_q <= 1'b1;
                            resp_hi_q    <= fix_hi;
                            resp_lo_q    <= fix_lo;
                        end
                    end else if (flush) begin
                        state_q <= MD_DRAIN;
                    end
                end
                MD_DONE: if (flush || resp_ready) begin
                    state_q      <= MD_IDLE;
                    resp_valid_q <= 1'b0;
                end
                MD_DRAIN: if (unit_done) state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_slot  = resp_slot_q;
    assign resp_hi    = resp_hi_q;
    assign resp_lo    = resp_lo_q;
    assign unit_start = unit_start_q;
    assign unit_div   = unit_div_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
endmodule
